adau1761_i2s_port: RTL and testbench

- Slave-mode I2S serial port between FPGA audio logic and the ADAU1761 codec. It runs after codec configuration completes; the codec is configured as serial-port master, 64 BCLK per frame, 24-bit data.
- Captures ADC stereo samples from ADC_SDATA into a parallel valid/ready stream.
- Serializes a parallel stereo stream onto DAC_SDATA.
- All codec pins are oversampled in the system clock domain; the block has no BCLK clock domain.

---
 rtl/adau1761_i2s_port.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_adau1761_i2s_port.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adau1761_i2s_port.sv
// Slave-mode I2S port for the ADAU1761 codec: BCLK/LRCLK/ADC pins are oversampled in the clk
// domain; ADC pairs are deserialized to a valid/ready stream, tx pairs are serialized to DAC.
module adau1761_i2s_port #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned SLOT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              bclk,
    input  logic              lrclk,
    input  logic              adc_sdata,
    output logic              dac_sdata,
    output logic [DATA_W-1:0] rx_left,
    output logic [DATA_W-1:0] rx_right,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_left,
    input  logic [DATA_W-1:0] tx_right,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              rx_overrun,
    output logic              tx_underrun,
    output logic              frame_err
);

    localparam int unsigned CNT_W = $clog2(SLOT_W + 1);
    localparam int unsigned IDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SLOT_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_RUN
    } state_t;

    // Pin synchronizers
    logic bclk_s1_q, bclk_s2_q, bclk_prev_q;
    logic lr_s1_q, lr_s2_q;
    logic adc_s1_q, adc_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_s1_q   <= 1'b0;
            bclk_s2_q   <= 1'b0;
            bclk_prev_q <= 1'b0;
            lr_s1_q     <= 1'b0;
            lr_s2_q     <= 1'b0;
            adc_s1_q    <= 1'b0;
            adc_s2_q    <= 1'b0;
        end else begin
            bclk_s1_q   <= bclk;
            bclk_s2_q   <= bclk_s1_q;
            bclk_prev_q <= bclk_s2_q;
            lr_s1_q     <= lrclk;
            lr_s2_q     <= lr_s1_q;
            adc_s1_q    <= adc_sdata;
            adc_s2_q    <= adc_s1_q;
        end
    end

    logic bclk_rise, bclk_fall;
    assign bclk_rise = bclk_s2_q & ~bclk_prev_q;
    assign bclk_fall = ~bclk_s2_q & bclk_prev_q;

    state_t            state_q, state_d;
    logic              lr_prev_q, lr_prev_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] left_hold_q, left_hold_d;
    logic              pair_done_q, pair_done_d;
    logic [DATA_W-1:0] rx_left_q, rx_left_d;
    logic [DATA_W-1:0] rx_right_q, rx_right_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_overrun_q, rx_overrun_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d;
    logic [DATA_W-1:0] hold_r_q, hold_r_d;
    logic              hold_full_q, hold_full_d;
    logic              tx_ready_q, tx_ready_d;
    logic [DATA_W-1:0] tx_l_q, tx_l_d;
    logic [DATA_W-1:0] tx_r_q, tx_r_d;
    logic              tx_underrun_q, tx_underrun_d;
    logic              frame_err_q, frame_err_d;
    logic              dac_q, dac_d;

    logic              in_range;
    logic [IDX_W-1:0]  tx_idx;
    logic [DATA_W-1:0] tx_word;
    logic              accept;
    logic              left_start;
    logic              leave;

    assign in_range = (bit_cnt_q >= CNT_ONE) && (bit_cnt_q <= CNT_DATA);
    assign tx_idx   = IDX_W'(CNT_DATA - bit_cnt_q);
    assign tx_word  = lr_prev_q ? tx_r_q : tx_l_q;
    assign accept   = tx_valid && tx_ready_q;

    // Next-state and datapath
    always_comb begin
        state_d       = state_q;
        lr_prev_d     = lr_prev_q;
        bit_cnt_d     = bit_cnt_q;
        rx_sh_d       = rx_sh_q;
        left_hold_d   = left_hold_q;
        pair_done_d   = 1'b0;
        rx_left_d     = rx_left_q;
        rx_right_d    = rx_right_q;
        rx_valid_d    = rx_valid_q;
        rx_overrun_d  = rx_overrun_q;
        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
        hold_full_d   = hold_full_q;
        tx_l_d        = tx_l_q;
        tx_r_d        = tx_r_q;
        tx_underrun_d = tx_underrun_q;
        frame_err_d   = frame_err_q;
        dac_d         = dac_q;
        left_start    = 1'b0;
        leave         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                dac_d = 1'b0;
                if (en) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    leave   = 1'b1;
                end else if (bclk_rise && lr_prev_q && !lr_s2_q) begin
                    state_d    = ST_RUN;
                    bit_cnt_d  = CNT_ONE;
                    rx_sh_d    = '0;
                    left_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    leave   = 1'b1;
                end else begin
                    if (bclk_rise) begin
                        if (lr_s2_q != lr_prev_q) begin
                            // Slot position 0: a short previous slot loses its partial word
                            if (bit_cnt_q < CNT_FULL) begin
                                frame_err_d = 1'b1;
                            end
                            bit_cnt_d  = CNT_ONE;
                            rx_sh_d    = '0;
                            left_start = !lr_s2_q;
                        end else begin
                            if (in_range) begin
                                rx_sh_d = {rx_sh_q[DATA_W-2:0], adc_s2_q};
                                if (bit_cnt_q == CNT_DATA) begin
                                    if (lr_prev_q) begin
                                        pair_done_d = 1'b1;
                                    end else begin
                                        left_hold_d = rx_sh_d;
                                    end
                                end
                            end
                            if (bit_cnt_q != CNT_SAT) begin
                                bit_cnt_d = bit_cnt_q + CNT_ONE;
                            end
                        end
                    end
                    if (bclk_fall) begin
                        dac_d = in_range ? tx_word[tx_idx] : 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bclk_rise) begin
            lr_prev_d = lr_s2_q;
        end

        // Frame-start tx load; an accept in the same clk refills holding for the next frame
        if (left_start) begin
            if (hold_full_q) begin
                tx_l_d      = hold_l_q;
                tx_r_d      = hold_r_q;
                hold_full_d = 1'b0;
            end else begin
                tx_l_d        = '0;
                tx_r_d        = '0;
                tx_underrun_d = 1'b1;
            end
        end
        if (accept) begin
            hold_l_d    = tx_left;
            hold_r_d    = tx_right;
            hold_full_d = 1'b1;
        end

        if (pair_done_q) begin
            rx_left_d  = left_hold_q;
            rx_right_d = rx_sh_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_ready) begin
                rx_overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (leave) begin
            bit_cnt_d     = '0;
            rx_sh_d       = '0;
            rx_valid_d    = 1'b0;
            rx_overrun_d  = 1'b0;
            hold_full_d   = 1'b0;
            tx_underrun_d = 1'b0;
            frame_err_d   = 1'b0;
            dac_d         = 1'b0;
        end

        tx_ready_d = (state_d != ST_IDLE) && !hold_full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            lr_prev_q     <= 1'b0;
            bit_cnt_q     <= '0;
            rx_sh_q       <= '0;
            left_hold_q   <= '0;
            pair_done_q   <= 1'b0;
            rx_left_q     <= '0;
            rx_right_q    <= '0;
            rx_valid_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            hold_full_q   <= 1'b0;
            tx_ready_q    <= 1'b0;
            tx_l_q        <= '0;
            tx_r_q        <= '0;
            tx_underrun_q <= 1'b0;
            frame_err_q   <= 1'b0;
            dac_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            lr_prev_q     <= lr_prev_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_sh_q       <= rx_sh_d;
            left_hold_q   <= left_hold_d;
            pair_done_q   <= pair_done_d;
            rx_left_q     <= rx_left_d;
            rx_right_q    <= rx_right_d;
            rx_valid_q    <= rx_valid_d;
            rx_overrun_q  <= rx_overrun_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            hold_full_q   <= hold_full_d;
            tx_ready_q    <= tx_ready_d;
            tx_l_q        <= tx_l_d;
            tx_r_q        <= tx_r_d;
            tx_underrun_q <= tx_underrun_d;
            frame_err_q   <= frame_err_d;
            dac_q         <= dac_d;
        end
    end

    assign dac_sdata   = dac_q;
    assign rx_left     = rx_left_q;
    assign rx_right    = rx_right_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = tx_ready_q;
    assign rx_overrun  = rx_overrun_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_adau1761_i2s_port.sv
// Bench for adau1761_i2s_port: a codec model drives I2S frames of random ADC words and
// records what appears on DAC_SDATA per frame; expectations come from frame-level rules.
module tb_adau1761_i2s_port;

    localparam int HALF_BCLK = 160;

    logic        clk = 1'b0;
    logic        rst_n, en, bclk, lrclk, adc_src, adc_sdata, dac_sdata, loop;
    logic [23:0] rx_left, rx_right, tx_left, tx_right;
    logic        rx_valid, rx_ready, tx_valid, tx_ready;
    logic        rx_overrun, tx_underrun, frame_err;

    int          total = 0;
    int          bad = 0;
    int          frame_no = 0;
    int          short_frame = -1;
    logic [23:0] gen_l [0:127];
    logic [23:0] gen_r [0:127];
    logic [23:0] dac_l [0:127];
    logic [23:0] dac_r [0:127];
    logic        dac_nz [0:127];
    logic [47:0] rx_q [$];

    always #5 clk = ~clk;

    assign adc_sdata = loop ? dac_sdata : adc_src;

    adau1761_i2s_port dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .adc_sdata  (adc_sdata),
        .dac_sdata  (dac_sdata),
        .rx_left    (rx_left),
        .rx_right   (rx_right),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_left    (tx_left),
        .tx_right   (tx_right),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_overrun (rx_overrun),
        .tx_underrun(tx_underrun),
        .frame_err  (frame_err)
    );

    // Codec model: 64-BCLK I2S frames, data changes on falling BCLK, MSB one BCLK after LRCLK
    initial begin : codec
        logic [23:0] wl, wr, word, dl, dr;
        logic        nz;
        int          cur, len;
        bclk = 1'b1;
        lrclk = 1'b1;
        adc_src = 1'b0;
        forever begin
            cur = frame_no + 1;
            wl = 24'($urandom);
            wr = 24'($urandom);
            gen_l[cur] = wl;
            gen_r[cur] = wr;
            dl = '0;
            dr = '0;
            nz = 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                word = (ch == 0) ? wl : wr;
                len = (ch == 1 && cur == short_frame) ? 10 : 32;
                for (int p = 0; p < len; p++) begin
                    #HALF_BCLK bclk = 1'b0;
                    if (p == 0) begin
                        lrclk = (ch == 1);
                        if (ch == 0) frame_no = cur;
                    end
                    adc_src = (p >= 1 && p <= 24) ? word[24-p] : 1'b0;
                    #HALF_BCLK bclk = 1'b1;
                    if (dac_sdata) nz = 1'b1;
                    if (p >= 1 && p <= 24) begin
                        if (ch == 0) dl[24-p] = dac_sdata;
                        else dr[24-p] = dac_sdata;
                    end
                end
            end
            dac_l[cur] = dl;
            dac_r[cur] = dr;
            dac_nz[cur] = nz;
        end
    end

    always @(posedge clk) begin
        if (rx_valid && rx_ready) rx_q.push_back({rx_left, rx_right});
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rx_at(input int k);
        return (k < rx_q.size()) ? 64'(rx_q[k]) : 64'hDEAD_0000_0000_0000;
    endfunction

    // Returns ~300 ns after the codec starts a new left slot
    task automatic wait_frame();
        int start_f, n;
        start_f = frame_no;
        n = 0;
        while (frame_no == start_f && n < 4000) begin
            @(posedge clk);
            n++;
        end
        check("frame_wait", 64'(n < 4000), 64'd1);
        repeat (30) @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [23:0] l, input logic [23:0] r);
        int n;
        n = 0;
        while (!tx_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tx_ready_wait", 64'(n < 200), 64'd1);
        tx_left = l;
        tx_right = r;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    initial begin : stim
        int          f0, g;
        logic [23:0] pl [0:7];
        logic [23:0] pr [0:7];

        rst_n = 1'b0;
        en = 1'b1;
        rx_ready = 1'b1;
        tx_valid = 1'b0;
        tx_left = '0;
        tx_right = '0;
        loop = 1'b0;
        for (int k = 0; k < 8; k++) begin
            pl[k] = 24'($urandom);
            pr[k] = 24'($urandom);
        end
        pl[0] = 24'h123456;
        pr[0] = 24'hABCDEF;
        pl[7] = pl[7] | 24'h003000;

        // Reset held with BCLK running and en high
        repeat (3000) @(posedge clk);
        #1;
        check("reset_outputs", 64'({dac_sdata, rx_left, rx_right, rx_valid, tx_ready,
                                    rx_overrun, tx_underrun, frame_err}), 64'd0);
        wait_frame();
        repeat (200) @(posedge clk);
        #1;
        rst_n = 1'b1;
        f0 = frame_no;

        // First left-slot start: sync with an empty holding register
        wait_frame();
        check("no_rx_before_sync", 64'(rx_q.size()), 64'd0);
        check("underrun_at_sync", 64'(tx_underrun), 64'd1);
        wait_frame();
        check("first_pair_count", 64'(rx_q.size()), 64'd1);
        check("first_pair", rx_at(0), 64'({gen_l[f0+1], gen_r[f0+1]}));
        check("underrun_dac_zero", 64'(dac_nz[f0+1]), 64'd0);
        check("no_frame_err", 64'({rx_overrun, frame_err}), 64'd0);

        // Pair offered after underrun plays on the next frame
        offer(pl[6], pr[6]);
        check("tx_ready_drop", 64'(tx_ready), 64'd0);
        wait_frame();
        wait_frame();
        check("dac_left", 64'(dac_l[f0+3]), 64'(pl[6]));
        check("dac_right", 64'(dac_r[f0+3]), 64'(pr[6]));

        // Disable mid-frame at bit 12 of the left slot
        offer(pl[7], pr[7]);
        wait_frame();
        repeat (360) @(posedge clk);
        #1;
        check("dac_mid_bit", 64'(dac_sdata), 64'd1);
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("disable_clear", 64'({dac_sdata, rx_valid, rx_overrun, tx_underrun, frame_err,
                                    tx_ready}), 64'd0);

        // Loopback with resync on the next left-slot start
        loop = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        en = 1'b1;
        rx_q.delete();
        offer(pl[0], pr[0]);
        for (int k = 1; k <= 4; k++) begin
            wait_frame();
            offer(pl[k], pr[k]);
        end
        wait_frame();
        g = frame_no;
        check("loop_count", 64'(rx_q.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("loop_pair%0d", k), rx_at(k), 64'({pl[k], pr[k]}));
        end
        check("loop_flags", 64'({rx_overrun, tx_underrun, frame_err}), 64'd0);

        // Overrun: two pairs complete while rx_ready is low
        rx_ready = 1'b0;
        offer(pl[5], pr[5]);
        wait_frame();
        wait_frame();
        check("overrun_flag", 64'(rx_overrun), 64'd1);
        check("overrun_valid", 64'(rx_valid), 64'd1);
        check("overrun_left", 64'(rx_left), 64'(pl[5]));
        check("overrun_right", 64'(rx_right), 64'(pr[5]));
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("valid_clear", 64'(rx_valid), 64'd0);

        // Short right slot of 10 BCLKs
        loop = 1'b0;
        check("frame_err_before", 64'(frame_err), 64'd0);
        short_frame = frame_no + 1;
        wait_frame();
        rx_q.delete();
        wait_frame();
        check("short_no_pair", 64'(rx_q.size()), 64'd0);
        check("frame_err_set", 64'(frame_err), 64'd1);
        g = frame_no;
        wait_frame();
        check("resume_count", 64'(rx_q.size()), 64'd1);
        check("resume_pair", rx_at(0), 64'({gen_l[g], gen_r[g]}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
